// File: rtl/gpr_bus_sequencer_if.sv
// gpr_bus_sequencer_if
//   Bundles the request handshake, operand selects and GPR strobes that run
//   between instruction decode (master) and the GPR bus sequencer (slave).
//   Signals:
//     req_valid/req_ready      transfer request handshake
//     req_src/req_src_ext      transfer source (GPR index, or external driver)
//     req_dst                  transfer destination GPR
//     lhs_en/lhs_sel           LHS ALU operand select
//     rhs_en/rhs_sel           RHS ALU operand select
//     main_assert_n, load      main-bus strobes (active-low assert, active-high load)
//     lhs_assert_n, rhs_assert_n  operand bus strobes (active-low)
//     done, busy               transfer status
interface gpr_bus_sequencer_if #(
  parameter int NUM_REGS = 4,
  parameter int SEL_W    = 2
);
  logic                req_valid;
  logic                req_ready;
  logic [SEL_W-1:0]    req_src;
  logic                req_src_ext;
  logic [SEL_W-1:0]    req_dst;
  logic                lhs_en;
  logic [SEL_W-1:0]    lhs_sel;
  logic                rhs_en;
  logic [SEL_W-1:0]    rhs_sel;
  logic [NUM_REGS-1:0] main_assert_n;
  logic [NUM_REGS-1:0] load;
  logic [NUM_REGS-1:0] lhs_assert_n;
  logic [NUM_REGS-1:0] rhs_assert_n;
  logic                done;
  logic                busy;

  modport master (
    output req_valid, req_src, req_src_ext, req_dst,
           lhs_en, lhs_sel, rhs_en, rhs_sel,
    input  req_ready, main_assert_n, load, lhs_assert_n, rhs_assert_n, done, busy
  );

  modport slave (
    input  req_valid, req_src, req_src_ext, req_dst,
           lhs_en, lhs_sel, rhs_en, rhs_sel,
    output req_ready, main_assert_n, load, lhs_assert_n, rhs_assert_n, done, busy
  );
endinterface

// File: rtl/gpr_bus_sequencer.sv
// gpr_bus_sequencer
//   Control-side driver for the GPR group. Sequences one register transfer at a
//   time over the shared main bus (GPR->GPR or external->GPR) with
//   break-before-make, and registers the LHS/RHS operand selects.
//   Ports:
//     clk   system clock, rising edge
//     rst   synchronous reset, active-high
//     bus   gpr_bus_sequencer_if.slave (request handshake, selects, strobes, status)
//
//   state | meaning
//   ------+----------------------------------------------------------
//   IDLE  | ready for a request; all main-bus strobes inactive
//   DRIVE | source drives main bus for SETTLE_CYCLES cycles
//   LOAD  | source still driving, destination load pulse high
//   GAP   | bus released (all 1s), done pulse; guaranteed dead cycle
module gpr_bus_sequencer #(
  parameter int NUM_REGS      = 4,
  parameter int SEL_W         = 2,
  parameter int SETTLE_CYCLES = 1
) (
  input logic              clk,
  input logic              rst,
  gpr_bus_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    LOAD  = 2'd2,
    GAP   = 2'd3
  } state_t;

  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(SETTLE_CYCLES - 1);

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic [SEL_W-1:0]    dst_q;
  logic [NUM_REGS-1:0] main_n_q;
  logic [NUM_REGS-1:0] load_q;
  logic                done_q;
  logic [NUM_REGS-1:0] lhs_n_q;
  logic [NUM_REGS-1:0] rhs_n_q;

  // Indices at or beyond NUM_REGS match no bit, so the strobe stays inactive.
  function automatic logic [NUM_REGS-1:0] onehot(input logic [SEL_W-1:0] idx);
    logic [NUM_REGS-1:0] v;
    v = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (int'(idx) == i) v[i] = 1'b1;
    end
    return v;
  endfunction

  // Transfer FSM. The settle timer is loaded on accept and counts down;
  // terminal count (zero) moves DRIVE to LOAD.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      dst_q    <= '0;
      main_n_q <= '1;
      load_q   <= '0;
      done_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_q   <= 1'b0;
          load_q   <= '0;
          main_n_q <= '1;
          if (bus.req_valid) begin
            dst_q    <= bus.req_dst;
            cnt      <= CNT_TOP;
            // External source: the bus is driven from outside, assert no GPR.
            main_n_q <= bus.req_src_ext ? '1 : ~onehot(bus.req_src);
            state    <= DRIVE;
          end
        end
        DRIVE: begin
          if (cnt == '0) begin
            load_q <= onehot(dst_q);
            state  <= LOAD;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        LOAD: begin
          // Release the bus and drop the load in the same edge; GAP is the
          // dead cycle that keeps successive drivers from overlapping.
          load_q   <= '0;
          main_n_q <= '1;
          done_q   <= 1'b1;
          state    <= GAP;
        end
        GAP: begin
          done_q <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          state    <= IDLE;
          main_n_q <= '1;
          load_q   <= '0;
          done_q   <= 1'b0;
        end
      endcase
    end
  end

  // Operand selects run every cycle, independent of any transfer in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      lhs_n_q <= '1;
      rhs_n_q <= '1;
    end else begin
      lhs_n_q <= bus.lhs_en ? ~onehot(bus.lhs_sel) : '1;
      rhs_n_q <= bus.rhs_en ? ~onehot(bus.rhs_sel) : '1;
    end
  end

  assign bus.main_assert_n = main_n_q;
  assign bus.load          = load_q;
  assign bus.done          = done_q;
  assign bus.lhs_assert_n  = lhs_n_q;
  assign bus.rhs_assert_n  = rhs_n_q;
  assign bus.req_ready     = (state == IDLE);
  assign bus.busy          = (state != IDLE);

endmodule
